// File: rtl/dpbram_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// dpbram_seq_ctrl_if
// Bundles the run/done control handshake and both BRAM port buses of the
// dual-port BRAM sequencer.
//   slave  : sequencer side (takes control inputs and qout_b, drives the rest)
//   master : control master + BRAM side (the mirror image)
// Signals
//   i_run, i_stop, i_mode, i_base, i_cnt, i_seed : transfer control
//   o_idle, o_write, o_read, o_done              : status / completion pulse
//   addr_a, en_a, we_a, din_a                    : BRAM port A (write)
//   addr_b, en_b, qout_b                         : BRAM port B (read)
//   o_valid, o_mem_data                          : registered read-back
//   o_err_cnt                                    : only with DPBRAM_CTRL_CHECK_EN
// -----------------------------------------------------------------------------
interface dpbram_seq_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 7
);
   logic                  i_run;
   logic                  i_stop;
   logic [1:0]            i_mode;
   logic [ADDR_WIDTH-1:0] i_base;
   logic [ADDR_WIDTH:0]   i_cnt;
   logic [DATA_WIDTH-1:0] i_seed;
   logic                  o_idle;
   logic                  o_write;
   logic                  o_read;
   logic                  o_done;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic                  en_a;
   logic                  we_a;
   logic [DATA_WIDTH-1:0] din_a;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic                  en_b;
   logic [DATA_WIDTH-1:0] qout_b;
   logic                  o_valid;
   logic [DATA_WIDTH-1:0] o_mem_data;
`ifdef DPBRAM_CTRL_CHECK_EN
   logic [ADDR_WIDTH:0]   o_err_cnt;
`endif

   modport slave (
      input  i_run, i_stop, i_mode, i_base, i_cnt, i_seed, qout_b,
      output o_idle, o_write, o_read, o_done,
             addr_a, en_a, we_a, din_a, addr_b, en_b,
             o_valid, o_mem_data
`ifdef DPBRAM_CTRL_CHECK_EN
      , output o_err_cnt
`endif
   );

   modport master (
      output i_run, i_stop, i_mode, i_base, i_cnt, i_seed, qout_b,
      input  o_idle, o_write, o_read, o_done,
             addr_a, en_a, we_a, din_a, addr_b, en_b,
             o_valid, o_mem_data
`ifdef DPBRAM_CTRL_CHECK_EN
      , input o_err_cnt
`endif
   );
endinterface

// File: rtl/dpbram_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dpbram_seq_ctrl
// Sequencer for a true dual-port BRAM (1-cycle read latency). Port A writes the
// pattern (seed+idx) over a programmable, wrapping address window; port B then
// reads the window back and the words are presented registered on o_mem_data.
// Ports
//   clk, rst : single rising-edge clock, synchronous active-high reset
//   bus      : dpbram_seq_ctrl_if.slave (control, status, BRAM ports A/B,
//              read-back data)
// Configuration macro
//   DPBRAM_CTRL_CHECK_EN : when defined, every read-back word is compared with
//   the expected pattern and mismatches are counted on o_err_cnt (saturating,
//   cleared when a run is accepted).
// -----------------------------------------------------------------------------
module dpbram_seq_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int MEM_SIZE   = 128,
   parameter int ADDR_WIDTH = 7
) (
   input logic               clk,
   input logic               rst,
   dpbram_seq_ctrl_if.slave  bus
);
   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] MEM_WORDS = (AW+1)'(MEM_SIZE);
   localparam logic [AW:0] ONE       = (AW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] base_q;
   logic [AW:0]   cnt_q;
   logic [AW:0]   idx_q;
   logic [DW-1:0] seed_q;
   logic [1:0]    mode_q;
   logic [AW:0]   cnt_clamp;
   logic          last_idx;
   logic          accept;

   // Pattern word for transfer index idx (wraps mod 2^DW naturally).
   function automatic logic [DW-1:0] pattern(input logic [DW-1:0] seed,
                                             input logic [AW:0]   idx);
      return seed + DW'(idx);
   endfunction

   assign cnt_clamp = (bus.i_cnt > MEM_WORDS) ? MEM_WORDS : bus.i_cnt;
   assign last_idx  = (idx_q == cnt_q - ONE);
   assign accept    = (state == S_IDLE) && bus.i_run;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (bus.i_run) begin
               if (cnt_clamp == '0)          state_nxt = S_DONE;
               else if (bus.i_mode == 2'b10) state_nxt = S_READ;
               else                          state_nxt = S_WRITE;
            end
         // A stop while writing leaves no reads in flight, so finish directly.
         S_WRITE:
            if (bus.i_stop)    state_nxt = S_DONE;
            else if (last_idx) state_nxt = (mode_q == 2'b01) ? S_DONE : S_READ;
         // Reads are always outstanding here; DRAIN lets the last one land.
         S_READ:
            if (bus.i_stop || last_idx) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.o_idle  = 1'b0;
      bus.o_write = 1'b0;
      bus.o_read  = 1'b0;
      bus.o_done  = 1'b0;
      bus.en_a    = 1'b0;
      bus.we_a    = 1'b0;
      bus.addr_a  = '0;
      bus.din_a   = '0;
      bus.en_b    = 1'b0;
      bus.addr_b  = '0;
      case (state)
         S_IDLE:  bus.o_idle = 1'b1;
         S_WRITE: begin
            bus.o_write = 1'b1;
            bus.en_a    = 1'b1;
            bus.we_a    = 1'b1;
            bus.addr_a  = base_q + idx_q[AW-1:0];
            bus.din_a   = pattern(seed_q, idx_q);
         end
         S_READ: begin
            bus.o_read = 1'b1;
            bus.en_b   = 1'b1;
            bus.addr_b = base_q + idx_q[AW-1:0];
         end
         S_DRAIN: bus.o_read = 1'b1;
         S_DONE:  bus.o_done = 1'b1;
         default: ;
      endcase
   end

   // Transfer control registers; idx restarts at 0 for the read phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         mode_q <= '0;
         idx_q  <= '0;
      end else begin
         if (accept) begin
            cnt_q  <= cnt_clamp;
            mode_q <= bus.i_mode;
         end
         case (state)
            S_WRITE: idx_q <= last_idx ? '0 : idx_q + ONE;
            S_READ:  idx_q <= idx_q + ONE;
            default: idx_q <= '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         base_q <= bus.i_base;
         seed_q <= bus.i_seed;
      end
   end

   // ---- stage p1: BRAM read data (qout_b) valid one cycle after en_b ----
   logic          vld_p1;
   logic          vld_p2;
   logic [DW-1:0] mem_data_p2;

   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= (state == S_READ);
   end

   // ---- stage p2: registered read-back output ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2      <= 1'b0;
         mem_data_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) mem_data_p2 <= bus.qout_b;
      end
   end

   assign bus.o_valid    = vld_p2;
   assign bus.o_mem_data = mem_data_p2;

`ifdef DPBRAM_CTRL_CHECK_EN
   logic [AW:0] idx_p1;
   logic [AW:0] err_q;

   function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction

   always_ff @(posedge clk) begin
      idx_p1 <= idx_q;
   end

   // Compare at p1 so the count moves in the same cycle the word appears.
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= '0;
      else if (accept)
         err_q <= '0;
      else if (vld_p1 && (bus.qout_b != pattern(seed_q, idx_p1)))
         err_q <= sat_inc(err_q);
   end

   assign bus.o_err_cnt = err_q;
`endif
endmodule

// File: tb/tb_dpbram_seq_ctrl.sv
module tb_dpbram_seq_ctrl;
   localparam int DW = 16;
   localparam int MS = 128;
   localparam int AW = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dpbram_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   dpbram_seq_ctrl #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // true dual-port BRAM, registered read on port B
   logic [DW-1:0] bram [MS];
   always @(posedge clk) begin
      if (bus.en_a && bus.we_a) bram[bus.addr_a] <= bus.din_a;
      if (bus.en_b) bus.qout_b <= bram[bus.addr_b];
   end

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [DW-1:0] mem_model [MS];
   int            ewa[$], era[$];
   logic [DW-1:0] ewd[$], erd[$];
   int            exp_done_cyc, exp_err;

   // observed
   int            awa[$], ara[$];
   logic [DW-1:0] awd[$], ard[$];
   int            act_done, act_done_cyc, collide;
   bit            v_in_done, idle_after;

   task automatic model_run(input logic [1:0] mode, input int base, input int cnt,
                            input logic [DW-1:0] seed, input int stop_after);
      int n, wr, rd, a;
      logic [DW-1:0] d;
      ewa.delete(); ewd.delete(); era.delete(); erd.delete();
      exp_err = 0;
      n  = (cnt > MS) ? MS : cnt;
      wr = (mode != 2'b10) ? n : 0;
      rd = (mode != 2'b01) ? n : 0;
      if (stop_after > 0 && rd > stop_after) rd = stop_after;
      for (int k = 0; k < wr; k++) begin
         a = (base + k) % MS;
         d = seed + DW'(k);
         ewa.push_back(a); ewd.push_back(d);
         mem_model[a] = d;
      end
      for (int k = 0; k < rd; k++) begin
         a = (base + k) % MS;
         era.push_back(a); erd.push_back(mem_model[a]);
         if (mem_model[a] != seed + DW'(k)) exp_err++;
      end
      exp_done_cyc = (rd > 0) ? wr + rd + 1 : wr;
   endtask

   task automatic run_xfer(input logic [1:0] mode, input int base, input int cnt,
                           input logic [DW-1:0] seed, input int stop_after, input bit hold_run);
      int reads;
      awa.delete(); awd.delete(); ara.delete(); ard.delete();
      act_done = 0; act_done_cyc = -1; collide = 0; v_in_done = 0; idle_after = 0;
      reads = 0;
      @(negedge clk);
      bus.i_mode = mode; bus.i_base = AW'(base); bus.i_cnt = (AW+1)'(cnt);
      bus.i_seed = seed; bus.i_run = 1'b1;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(negedge clk);
         if (!hold_run) bus.i_run = 1'b0;
         if (bus.en_a) begin awa.push_back(int'(bus.addr_a)); awd.push_back(bus.din_a); end
         if (bus.en_b) begin ara.push_back(int'(bus.addr_b)); reads++; end
         if (bus.en_a && bus.en_b) collide++;
         if (bus.o_valid) ard.push_back(bus.o_mem_data);
         if (bus.o_valid && bus.o_done) v_in_done = 1;
         bus.i_stop = (stop_after > 0) && bus.en_b && (reads == stop_after);
         if (bus.o_done) begin
            act_done++;
            if (act_done_cyc < 0) act_done_cyc = cyc;
         end
         if (act_done_cyc >= 0 && cyc == act_done_cyc + 1) begin
            idle_after = bus.o_idle && !bus.o_write && !bus.o_read;
            bus.i_run = 1'b0;
         end
         if (act_done_cyc >= 0 && cyc >= act_done_cyc + 3) break;
      end
      bus.i_stop = 1'b0;
      bus.i_run  = 1'b0;
   endtask

   task automatic test_reset();
      bus.i_run = 0; bus.i_stop = 0; bus.i_mode = 0; bus.i_base = 0; bus.i_cnt = 0; bus.i_seed = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.o_idle !== 1'b1 || bus.o_write !== 1'b0 || bus.o_read !== 1'b0 || bus.o_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_status: got idle=%b wr=%b rd=%b done=%b want 1 0 0 0",
                            bus.o_idle, bus.o_write, bus.o_read, bus.o_done);
      end
      n_checks++;
      if (bus.en_a !== 0 || bus.we_a !== 0 || bus.en_b !== 0 || bus.addr_a !== 0 || bus.din_a !== 0 || bus.addr_b !== 0) begin
         n_fail++; $display("FAIL reset_ports: got en_a=%b we_a=%b en_b=%b addr_a=%0d din_a=%h addr_b=%0d want all 0",
                            bus.en_a, bus.we_a, bus.en_b, bus.addr_a, bus.din_a, bus.addr_b);
      end
      n_checks++;
      if (bus.o_valid !== 1'b0 || bus.o_mem_data !== '0) begin
         n_fail++; $display("FAIL reset_readback: got valid=%b data=%h want 0 0000", bus.o_valid, bus.o_mem_data);
      end
`ifdef DPBRAM_CTRL_CHECK_EN
      n_checks++;
      if (bus.o_err_cnt !== '0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", bus.o_err_cnt); end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_len_edges();
      string tag;
      int cnts[2] = '{0, 200};
      for (int t = 0; t < 2; t++) begin
         logic [DW-1:0] seed = DW'($urandom);
         tag = (t == 0) ? "len0" : "len200";
         model_run(2'b00, 0, cnts[t], seed, 0);
         run_xfer(2'b00, 0, cnts[t], seed, 0, 0);
         n_checks++;
         if (awa.size() != ewa.size()) begin n_fail++; $display("FAIL %s wr_count: got %0d want %0d", tag, awa.size(), ewa.size()); end
         foreach (ewa[k]) if (k < awa.size()) begin
            n_checks++;
            if (awa[k] !== ewa[k] || awd[k] !== ewd[k]) begin n_fail++; $display("FAIL %s wr[%0d]: got %0d/%h want %0d/%h", tag, k, awa[k], awd[k], ewa[k], ewd[k]); end
         end
         n_checks++;
         if (ara.size() != era.size() || ard.size() != era.size()) begin n_fail++; $display("FAIL %s rd_count: got %0d en_b %0d valid want %0d", tag, ara.size(), ard.size(), era.size()); end
         foreach (era[k]) if (k < ara.size() && k < ard.size()) begin
            n_checks++;
            if (ara[k] !== era[k] || ard[k] !== erd[k]) begin n_fail++; $display("FAIL %s rd[%0d]: got %0d/%h want %0d/%h", tag, k, ara[k], ard[k], era[k], erd[k]); end
         end
         n_checks++;
         if (act_done != 1 || act_done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL %s done: got %0d pulses at cycle %0d want 1 at %0d", tag, act_done, act_done_cyc, exp_done_cyc); end
         n_checks++;
         if (collide != 0 || (era.size() > 0 && !v_in_done) || !idle_after) begin n_fail++; $display("FAIL %s timing: got collide=%0d last_valid_in_done=%b idle_after=%b want 0 1 1", tag, collide, v_in_done, idle_after); end
      end
   endtask

   task automatic test_pattern_runs();
      string tag;
      logic [1:0]    modes[6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
      int            bases[6] = '{0, 120, 40, 40, 40, 7};
      int            cnts [6] = '{100, 16, 8, 8, 8, 5};
      logic [DW-1:0] seeds[6] = '{16'h0000, 16'hFFF8, 16'h0005, 16'h0005, 16'h0006, 16'h1234};
      int            errs [6] = '{0, 0, 0, 0, 8, 0};
      for (int t = 0; t < 6; t++) begin
         $sformat(tag, "pat%0d", t);
         model_run(modes[t], bases[t], cnts[t], seeds[t], 0);
         run_xfer(modes[t], bases[t], cnts[t], seeds[t], 0, 0);
         n_checks++;
         if (awa.size() != ewa.size()) begin n_fail++; $display("FAIL %s wr_count: got %0d want %0d", tag, awa.size(), ewa.size()); end
         foreach (ewa[k]) if (k < awa.size()) begin
            n_checks++;
            if (awa[k] !== ewa[k] || awd[k] !== ewd[k]) begin n_fail++; $display("FAIL %s wr[%0d]: got %0d/%h want %0d/%h", tag, k, awa[k], awd[k], ewa[k], ewd[k]); end
         end
         n_checks++;
         if (ara.size() != era.size() || ard.size() != era.size()) begin n_fail++; $display("FAIL %s rd_count: got %0d en_b %0d valid want %0d", tag, ara.size(), ard.size(), era.size()); end
         foreach (era[k]) if (k < ara.size() && k < ard.size()) begin
            n_checks++;
            if (ara[k] !== era[k] || ard[k] !== erd[k]) begin n_fail++; $display("FAIL %s rd[%0d]: got %0d/%h want %0d/%h", tag, k, ara[k], ard[k], era[k], erd[k]); end
         end
         n_checks++;
         if (act_done != 1 || act_done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL %s done: got %0d pulses at cycle %0d want 1 at %0d", tag, act_done, act_done_cyc, exp_done_cyc); end
         n_checks++;
         if (collide != 0 || (era.size() > 0 && !v_in_done) || !idle_after) begin n_fail++; $display("FAIL %s timing: got collide=%0d last_valid_in_done=%b idle_after=%b want 0 1 1", tag, collide, v_in_done, idle_after); end
`ifdef DPBRAM_CTRL_CHECK_EN
         n_checks++;
         if (bus.o_err_cnt !== (AW+1)'(errs[t]) || exp_err != errs[t]) begin n_fail++; $display("FAIL %s err_cnt: got %0d (model %0d) want %0d", tag, bus.o_err_cnt, exp_err, errs[t]); end
`endif
      end
      // wrap points of the 120/16/FFF8 run, checked against the literal values
      model_run(2'b00, 120, 16, 16'hFFF8, 0);
      run_xfer(2'b00, 120, 16, 16'hFFF8, 0, 0);
      n_checks++;
      if (awa.size() < 9 || awa[7] !== 127 || awd[7] !== 16'hFFFF || awa[8] !== 0 || awd[8] !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_literal: got %0d words, [7]=%0d/%h [8]=%0d/%h want 127/ffff 0/0000",
                            awa.size(), (awa.size() > 7) ? awa[7] : -1, (awd.size() > 7) ? awd[7] : 16'hx,
                            (awa.size() > 8) ? awa[8] : -1, (awd.size() > 8) ? awd[8] : 16'hx);
      end
   endtask

   task automatic test_stop_and_reset();
      int wr_seen;
      logic [DW-1:0] seed = DW'($urandom);
      model_run(2'b00, 30, 10, seed, 3);
      run_xfer(2'b00, 30, 10, seed, 3, 0);
      n_checks++;
      if (ara.size() != 3 || ard.size() != 3) begin n_fail++; $display("FAIL stop_reads: got %0d en_b %0d valid want 3 3", ara.size(), ard.size()); end
      foreach (era[k]) if (k < ard.size()) begin
         n_checks++;
         if (ard[k] !== erd[k]) begin n_fail++; $display("FAIL stop_rd[%0d]: got %h want %h", k, ard[k], erd[k]); end
      end
      n_checks++;
      if (act_done != 1 || act_done_cyc != 14 || !v_in_done) begin n_fail++; $display("FAIL stop_done: got %0d pulses at cycle %0d in_done=%b want 1 at 14 1", act_done, act_done_cyc, v_in_done); end

      // reset during WRITE: three writes get committed before it takes effect
      @(negedge clk);
      bus.i_mode = 2'b00; bus.i_base = AW'(10); bus.i_cnt = (AW+1)'(20); bus.i_seed = seed; bus.i_run = 1'b1;
      @(negedge clk); bus.i_run = 1'b0; wr_seen = int'(bus.en_a);
      @(negedge clk); wr_seen += int'(bus.en_a);
      @(negedge clk); wr_seen += int'(bus.en_a); rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.o_idle !== 1'b1 || bus.en_a !== 1'b0 || bus.o_write !== 1'b0 || bus.o_valid !== 1'b0 || wr_seen != 3) begin
         n_fail++; $display("FAIL rst_mid_write: got idle=%b en_a=%b write=%b valid=%b writes=%0d want 1 0 0 0 3",
                            bus.o_idle, bus.en_a, bus.o_write, bus.o_valid, wr_seen);
      end
      for (int k = 0; k < 3; k++) mem_model[10 + k] = seed + DW'(k);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_run_hold();
      logic [DW-1:0] seed = DW'($urandom);
      model_run(2'b00, 64, 5, seed, 0);
      run_xfer(2'b00, 64, 5, seed, 0, 1);
      n_checks++;
      if (awa.size() != 5 || ara.size() != 5 || ard.size() != 5) begin n_fail++; $display("FAIL hold_counts: got wr=%0d rd=%0d valid=%0d want 5 5 5", awa.size(), ara.size(), ard.size()); end
      n_checks++;
      if (act_done != 1 || act_done_cyc != exp_done_cyc || !idle_after) begin n_fail++; $display("FAIL hold_done: got %0d pulses at cycle %0d idle_after=%b want 1 at %0d idle 1", act_done, act_done_cyc, idle_after, exp_done_cyc); end
   endtask

   task automatic test_random();
      string tag;
      for (int t = 0; t < 10; t++) begin
         logic [1:0]    mode = 2'($urandom_range(0, 3));
         int            base = $urandom_range(0, MS - 1);
         int            cnt  = $urandom_range(0, 140);
         logic [DW-1:0] seed = DW'($urandom);
         int            stp  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
         $sformat(tag, "rnd%0d", t);
         model_run(mode, base, cnt, seed, stp);
         run_xfer(mode, base, cnt, seed, stp, 0);
         n_checks++;
         if (awa.size() != ewa.size()) begin n_fail++; $display("FAIL %s wr_count: got %0d want %0d", tag, awa.size(), ewa.size()); end
         foreach (ewa[k]) if (k < awa.size()) begin
            n_checks++;
            if (awa[k] !== ewa[k] || awd[k] !== ewd[k]) begin n_fail++; $display("FAIL %s wr[%0d]: got %0d/%h want %0d/%h", tag, k, awa[k], awd[k], ewa[k], ewd[k]); end
         end
         n_checks++;
         if (ara.size() != era.size() || ard.size() != era.size()) begin n_fail++; $display("FAIL %s rd_count: got %0d en_b %0d valid want %0d", tag, ara.size(), ard.size(), era.size()); end
         foreach (era[k]) if (k < ara.size() && k < ard.size()) begin
            n_checks++;
            if (ara[k] !== era[k] || ard[k] !== erd[k]) begin n_fail++; $display("FAIL %s rd[%0d]: got %0d/%h want %0d/%h", tag, k, ara[k], ard[k], era[k], erd[k]); end
         end
         n_checks++;
         if (act_done != 1 || act_done_cyc != exp_done_cyc) begin n_fail++; $display("FAIL %s done: got %0d pulses at cycle %0d want 1 at %0d", tag, act_done, act_done_cyc, exp_done_cyc); end
         n_checks++;
         if (collide != 0 || (era.size() > 0 && !v_in_done) || !idle_after) begin n_fail++; $display("FAIL %s timing: got collide=%0d last_valid_in_done=%b idle_after=%b want 0 1 1", tag, collide, v_in_done, idle_after); end
`ifdef DPBRAM_CTRL_CHECK_EN
         n_checks++;
         if (bus.o_err_cnt !== (AW+1)'(exp_err)) begin n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", tag, bus.o_err_cnt, exp_err); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_len_edges();
      test_pattern_runs();
      test_stop_and_reset();
      test_run_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
